// File: rtl/door_motion_conditioner_pkg.sv
// Shared widths, defaults and FSM state encoding for the door motion conditioner.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package door_motion_conditioner_pkg;

  localparam int DOOR_MOTION_SENSOR_DATA_WIDTH = 1;
  localparam int DOOR_HOLD_CYCLES_DEFAULT      = 1000;

  typedef enum logic [1:0] {
    DMC_IDLE   = 2'd0,
    DMC_ACTIVE = 2'd1,
    DMC_HOLD   = 2'd2
  } dmc_state_t;

endpackage

// File: rtl/door_motion_conditioner_if.sv
// Bundles the raw sensor/manual request inputs and the conditioned occupancy outputs.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are levels or single-cycle pulses.
interface door_motion_conditioner_if;
  import door_motion_conditioner_pkg::*;

  logic                                     motion_raw;
  logic                                     manual_unlock;
  logic [DOOR_MOTION_SENSOR_DATA_WIDTH-1:0] door_motion_sensor;
  logic                                     hold_active;
  logic                                     motion_event;

  // Stimulus side: drives the raw inputs, observes the conditioned outputs.
  modport master (
    output motion_raw,
    output manual_unlock,
    input  door_motion_sensor,
    input  hold_active,
    input  motion_event
  );

  // Conditioner side.
  modport slave (
    input  motion_raw,
    input  manual_unlock,
    output door_motion_sensor,
    output hold_active,
    output motion_event
  );

endinterface

// File: rtl/motion_debouncer.sv
// Synchronises the async PIR level and debounces it over DEBOUNCE_CYCLES stable cycles.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES cycles from input sample to dout change.
// Backpressure: none; glitches shorter than DEBOUNCE_CYCLES synced cycles are dropped.
module motion_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  // A single-cycle debounce still needs a 1-bit counter to compare against zero.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_deb;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign dout   = r_deb;

  // Metastability chain: shift the raw level through SYNC_STAGES flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
    end
  end

  // Count consecutive disagreeing cycles; adopt the new level once the run is long enough.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_deb <= 1'b0;
    end else if (w_sync == r_deb) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      r_deb <= w_sync;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/door_motion_conditioner.sv
// Turns raw door motion into an occupancy level held for HOLD_CYCLES after the last motion.
// Latency: SYNC_STAGES+DEBOUNCE_CYCLES+1 cycles raw->output rise; manual unlock opens on its edge.
// Backpressure: none; manual_unlock is ignored while motion is active.
module door_motion_conditioner
  import door_motion_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = DOOR_HOLD_CYCLES_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  door_motion_conditioner_if.slave   bus
);

  localparam int HCNT_W = $clog2(HOLD_CYCLES + 1);

  logic              w_deb;
  dmc_state_t        r_state;
  logic [HCNT_W-1:0] r_hcnt;
  logic              r_sensor;
  logic              r_hold;
  logic              r_event;

  motion_debouncer #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk  (clk),
    .rst  (rst),
    .din  (bus.motion_raw),
    .dout (w_deb)
  );

  assign bus.door_motion_sensor = DOOR_MOTION_SENSOR_DATA_WIDTH'(r_sensor);
  assign bus.hold_active        = r_hold;
  assign bus.motion_event       = r_event;

  // Occupancy FSM with hold timer; outputs are registered from the next-state decision.
  // Debounced motion always wins over hold expiry and manual reload.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= DMC_IDLE;
      r_hcnt   <= '0;
      r_sensor <= 1'b0;
      r_hold   <= 1'b0;
      r_event  <= 1'b0;
    end else begin
      r_event <= 1'b0;
      case (r_state)
        DMC_IDLE: begin
          if (w_deb) begin
            r_state  <= DMC_ACTIVE;
            r_sensor <= 1'b1;
            r_hold   <= 1'b0;
            r_event  <= 1'b1;
          end else if (bus.manual_unlock) begin
            r_state  <= DMC_HOLD;
            r_hcnt   <= '0;
            r_sensor <= 1'b1;
            r_hold   <= 1'b1;
          end
        end
        DMC_ACTIVE: begin
          if (!w_deb) begin
            r_state  <= DMC_HOLD;
            r_hcnt   <= '0;
            r_sensor <= 1'b1;
            r_hold   <= 1'b1;
          end
        end
        DMC_HOLD: begin
          if (w_deb) begin
            r_state  <= DMC_ACTIVE;
            r_sensor <= 1'b1;
            r_hold   <= 1'b0;
          end else if (bus.manual_unlock) begin
            r_hcnt <= '0;
          end else if (r_hcnt == HCNT_W'(HOLD_CYCLES - 1)) begin
            r_state  <= DMC_IDLE;
            r_sensor <= 1'b0;
            r_hold   <= 1'b0;
          end else begin
            r_hcnt <= r_hcnt + HCNT_W'(1);
          end
        end
        default: begin
          r_state  <= DMC_IDLE;
          r_hcnt   <= '0;
          r_sensor <= 1'b0;
          r_hold   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_door_motion_conditioner.sv
// Directed scoreboard bench for door_motion_conditioner (SYNC=2, DEBOUNCE=4, HOLD=10).
// Latency: each driven cycle queues the hand-derived output expected after the next edge.
// Backpressure: n/a; a monitor pops one expectation per clock edge while the queue is non-empty.
module tb_door_motion_conditioner;
  import door_motion_conditioner_pkg::*;

  // Expected {door_motion_sensor, hold_active, motion_event}
  localparam logic [2:0] E_OFF = 3'b000;
  localparam logic [2:0] E_ACT = 3'b100;
  localparam logic [2:0] E_EVT = 3'b101;
  localparam logic [2:0] E_HLD = 3'b110;

  logic clk = 1'b0;
  logic rst;

  door_motion_conditioner_if bus_if ();

  door_motion_conditioner #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  logic [2:0] exp_q[$];
  int         id_q[$];
  int         checks  = 0;
  int         errors  = 0;
  int         step_no = 0;

  // Drive one cycle of inputs at the falling edge and queue the output expected after the next rise.
  task automatic drive(input logic raw, input logic mu, input logic r, input logic [2:0] exp);
    @(negedge clk);
    bus_if.motion_raw    = raw;
    bus_if.manual_unlock = mu;
    rst                  = r;
    exp_q.push_back(exp);
    id_q.push_back(step_no);
    step_no++;
  endtask

  task automatic drive_n(input int n, input logic raw, input logic mu, input logic r,
                         input logic [2:0] exp);
    for (int i = 0; i < n; i++) drive(raw, mu, r, exp);
  endtask

  // Monitor: compare DUT outputs shortly after each rising edge against the queued expectation.
  initial begin
    logic [2:0] got;
    logic [2:0] e;
    int         id;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        id  = id_q.pop_front();
        got = {bus_if.door_motion_sensor[0], bus_if.hold_active, bus_if.motion_event};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL step %0d {sensor,hold,event}: got %b required %b", id, got, e);
        end
      end
    end
  end

  initial begin
    rst                  = 1'b1;
    bus_if.motion_raw    = 1'b0;
    bus_if.manual_unlock = 1'b0;

    // Reset with motion already present: outputs stay low, rise 7 edges after the last reset edge.
    drive_n(2, 1'b1, 1'b0, 1'b1, E_OFF);
    drive_n(6, 1'b1, 1'b0, 1'b0, E_OFF);
    drive  (   1'b1, 1'b0, 1'b0, E_EVT);
    drive  (   1'b1, 1'b0, 1'b0, E_ACT);
    // Manual unlock while ACTIVE has no effect.
    drive  (   1'b1, 1'b1, 1'b0, E_ACT);
    drive_n(2, 1'b1, 1'b0, 1'b0, E_ACT);

    // Motion falls: hold for exactly 10 cycles, then back to idle.
    drive_n(6,  1'b0, 1'b0, 1'b0, E_ACT);
    drive_n(10, 1'b0, 1'b0, 1'b0, E_HLD);
    drive_n(3,  1'b0, 1'b0, 1'b0, E_OFF);

    // Three-cycle glitch is one short of the debounce window: nothing changes.
    drive_n(3, 1'b1, 1'b0, 1'b0, E_OFF);
    drive_n(8, 1'b0, 1'b0, 1'b0, E_OFF);

    // Clean rise from idle: single motion_event pulse.
    drive_n(6, 1'b1, 1'b0, 1'b0, E_OFF);
    drive  (   1'b1, 1'b0, 1'b0, E_EVT);
    drive_n(3, 1'b1, 1'b0, 1'b0, E_ACT);

    // Motion returns while hold counter is at 5: back to ACTIVE, no event, no output drop.
    drive_n(6, 1'b0, 1'b0, 1'b0, E_ACT);
    drive_n(6, 1'b1, 1'b0, 1'b0, E_HLD);
    drive_n(4, 1'b1, 1'b0, 1'b0, E_ACT);

    // Motion returns on the very cycle the hold would expire: ACTIVE wins.
    drive_n(6, 1'b0, 1'b0, 1'b0, E_ACT);
    drive_n(4, 1'b0, 1'b0, 1'b0, E_HLD);
    drive_n(6, 1'b1, 1'b0, 1'b0, E_HLD);
    drive_n(4, 1'b1, 1'b0, 1'b0, E_ACT);

    // Return to idle.
    drive_n(6,  1'b0, 1'b0, 1'b0, E_ACT);
    drive_n(10, 1'b0, 1'b0, 1'b0, E_HLD);
    drive_n(3,  1'b0, 1'b0, 1'b0, E_OFF);

    // Manual unlock in idle, reloaded 4 cycles later: window extends to 14 cycles total.
    drive  (   1'b0, 1'b1, 1'b0, E_HLD);
    drive_n(3, 1'b0, 1'b0, 1'b0, E_HLD);
    drive  (   1'b0, 1'b1, 1'b0, E_HLD);
    drive_n(9, 1'b0, 1'b0, 1'b0, E_HLD);
    drive_n(3, 1'b0, 1'b0, 1'b0, E_OFF);

    // Single manual unlock: exactly 10 cycles high.
    drive  (   1'b0, 1'b1, 1'b0, E_HLD);
    drive_n(9, 1'b0, 1'b0, 1'b0, E_HLD);
    drive_n(2, 1'b0, 1'b0, 1'b0, E_OFF);

    // Manual unlock cut short by reset three cycles in; no hold completion afterwards.
    drive  (   1'b0, 1'b1, 1'b0, E_HLD);
    drive_n(2, 1'b0, 1'b0, 1'b0, E_HLD);
    drive  (   1'b0, 1'b0, 1'b1, E_OFF);
    drive_n(12, 1'b0, 1'b0, 1'b0, E_OFF);

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
